debounce_sync: RTL and testbench

Upstream conditioning stage for the team's WD-wide D flip-flop register. It takes an asynchronous, possibly bouncing WD-bit input and synchronizes it through two flops. A new value is accepted only after it has been stable for STABLE_CYC consecutive clocks. The result is a clean registered word plus one-cycle change and edge pulses, ready to be captured by the downstream register.

---
 rtl/debounce_pkg.sv | 13 +
 rtl/debounce_sync_2ff.sv | 24 ++
 rtl/debounce_sync.sv | 90 +++++++++
 tb/tb_debounce_sync.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/debounce_pkg.sv
// Shared types and default sizing for the debounce_sync input conditioner.
// No datapath of its own; latency and backpressure are properties of the users.
package debounce_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    CHECK = 1'b1
  } state_t;

  localparam int DEF_WD         = 2;
  localparam int DEF_STABLE_CYC = 4;

endpackage

// File: rtl/debounce_sync_2ff.sv
// sync_2ff: two-flop synchronizer for a WD-bit asynchronous word, reset to 0.
// Latency 2 clk edges; no backpressure (free-running, samples every cycle).
module sync_2ff #(
  parameter int WD = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [WD-1:0] d,
  output logic [WD-1:0] q
);

  logic [WD-1:0] s1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1 <= '0;
      q  <= '0;
    end else begin
      s1 <= d;
      q  <= s1;
    end
  end

endmodule

// File: rtl/debounce_sync.sv
// debounce_sync: 2FF sync plus stable-count qualifier giving a clean WD-bit word and change/edge pulses.
// Latency STABLE_CYC+2 clk edges from d to q; no backpressure (never stalls, pulses are single-cycle).
module debounce_sync
  import debounce_pkg::*;
#(
  parameter int WD         = DEF_WD,
  parameter int STABLE_CYC = DEF_STABLE_CYC
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [WD-1:0] d,
  output logic [WD-1:0] q,
  output logic          chg,
  output logic [WD-1:0] rise,
  output logic [WD-1:0] fall,
  output logic          busy
);

  localparam int          CW   = $clog2(STABLE_CYC) + 1;
  localparam logic [CW-1:0] LAST = CW'(STABLE_CYC - 1);

  logic [WD-1:0] d_s;
  logic [WD-1:0] cand;
  logic [CW-1:0] cnt;
  state_t        state;

  sync_2ff #(
    .WD(WD)
  ) u_sync (
    .clk  (clk),
    .reset(reset),
    .d    (d),
    .q    (d_s)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cand  <= '0;
      cnt   <= '0;
      q     <= '0;
      chg   <= 1'b0;
      rise  <= '0;
      fall  <= '0;
    end else begin
      chg  <= 1'b0;
      rise <= '0;
      fall <= '0;
      case (state)
        IDLE: begin
          if (d_s != q) begin
            state <= CHECK;
            cand  <= d_s;
            cnt   <= CW'(1);
          end else begin
            cnt <= '0;
          end
        end
        CHECK: begin
          // Returning to the held value wins over completing qualification.
          if (d_s == q) begin
            state <= IDLE;
            cnt   <= '0;
          end else if (d_s != cand) begin
            cand <= d_s;
            cnt  <= CW'(1);
          end else if (cnt == LAST) begin
            q     <= cand;
            chg   <= 1'b1;
            rise  <= cand & ~q;
            fall  <= ~cand & q;
            cnt   <= '0;
            state <= IDLE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  assign busy = (state == CHECK);

  cnt_bounded: assert property (@(posedge clk) disable iff (reset) cnt <= LAST);

endmodule

// File: tb/tb_debounce_sync.sv
// Directed bench for debounce_sync with WD=2, STABLE_CYC=4: reset, glitch, step, reset mid-qualify, fall, bounce.
// Edges are counted from the first posedge after d changes; outputs are sampled 1ns after each posedge.
module tb_debounce_sync;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] d = 2'b00;
  logic [1:0] q;
  logic       chg;
  logic [1:0] rise;
  logic [1:0] fall;
  logic       busy;

  int checks = 0;
  int passes = 0;

  debounce_sync #(
    .WD        (2),
    .STABLE_CYC(4)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .d    (d),
    .q    (q),
    .chg  (chg),
    .rise (rise),
    .fall (fall),
    .busy (busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic test_reset();
    d = 2'b11;
    #2;
    checks++;
    if ({q, chg, rise, fall, busy} !== 8'b0)
      $display("FAIL reset_initial got q=%b chg=%b rise=%b fall=%b busy=%b required all 0", q, chg, rise, fall, busy);
    else passes++;
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if ({q, chg, rise, fall, busy} !== 8'b0)
        $display("FAIL reset_hold%0d got q=%b chg=%b rise=%b fall=%b busy=%b required all 0", i, q, chg, rise, fall, busy);
      else passes++;
    end
    d = 2'b00;
    reset = 1'b0;
    settle(4);
  endtask

  task automatic test_glitch();
    logic saw_busy;
    logic saw_chg;
    saw_busy = 1'b0;
    saw_chg  = 1'b0;
    d = 2'b01;
    for (int e = 0; e < 10; e++) begin
      step();
      if (e == 2) d = 2'b00;
      if (busy) saw_busy = 1'b1;
      if (chg)  saw_chg  = 1'b1;
      checks++;
      if (q !== 2'b00) $display("FAIL glitch_q edge%0d got=%b required=00", e, q);
      else passes++;
    end
    checks++;
    if (saw_busy !== 1'b1) $display("FAIL glitch_busy_rose got=%b required=1", saw_busy);
    else passes++;
    checks++;
    if (saw_chg !== 1'b0) $display("FAIL glitch_chg got=%b required=0", saw_chg);
    else passes++;
    checks++;
    if (busy !== 1'b0) $display("FAIL glitch_busy_end got=%b required=0", busy);
    else passes++;
  endtask

  task automatic test_clean_step();
    d = 2'b01;
    step(); step();
    checks++;
    if (busy !== 1'b0) $display("FAIL step_busy_e1 got=%b required=0", busy);
    else passes++;
    step();
    checks++;
    if (busy !== 1'b1) $display("FAIL step_busy_e2 got=%b required=1", busy);
    else passes++;
    step(); step();
    checks++;
    if ({q, chg} !== 3'b000) $display("FAIL step_e4 got q=%b chg=%b required q=00 chg=0", q, chg);
    else passes++;
    step();
    checks++;
    if ({q, chg, rise, fall, busy} !== 8'b01_1_01_00_0)
      $display("FAIL step_e5 got q=%b chg=%b rise=%b fall=%b busy=%b required q=01 chg=1 rise=01 fall=00 busy=0", q, chg, rise, fall, busy);
    else passes++;
    step();
    checks++;
    if ({q, chg, rise, fall} !== 7'b01_0_00_00)
      $display("FAIL step_e6 got q=%b chg=%b rise=%b fall=%b required q=01 chg=0 rise=00 fall=00", q, chg, rise, fall);
    else passes++;
    settle(2);
  endtask

  task automatic test_reset_mid_check();
    d = 2'b11;
    step(); step(); step(); step();
    checks++;
    if (busy !== 1'b1) $display("FAIL midrst_busy_before got=%b required=1", busy);
    else passes++;
    reset = 1'b1;
    #1;
    checks++;
    if ({q, chg, busy} !== 4'b0000) $display("FAIL midrst_async got q=%b chg=%b busy=%b required 0", q, chg, busy);
    else passes++;
    settle(2);
    reset = 1'b0;
    step(); step();
    checks++;
    if (busy !== 1'b0) $display("FAIL midrst_busy_e1 got=%b required=0", busy);
    else passes++;
    step(); step(); step();
    checks++;
    if (q !== 2'b00) $display("FAIL midrst_q_e4 got=%b required=00", q);
    else passes++;
    step();
    checks++;
    if ({q, chg, rise, fall} !== 7'b11_1_11_00)
      $display("FAIL midrst_e5 got q=%b chg=%b rise=%b fall=%b required q=11 chg=1 rise=11 fall=00", q, chg, rise, fall);
    else passes++;
    settle(2);
  endtask

  task automatic test_fall();
    d = 2'b00;
    step(); step(); step(); step(); step();
    checks++;
    if ({q, chg} !== 3'b110) $display("FAIL fall_e4 got q=%b chg=%b required q=11 chg=0", q, chg);
    else passes++;
    step();
    checks++;
    if ({q, chg, rise, fall} !== 7'b00_1_00_11)
      $display("FAIL fall_e5 got q=%b chg=%b rise=%b fall=%b required q=00 chg=1 rise=00 fall=11", q, chg, rise, fall);
    else passes++;
    step();
    checks++;
    if ({chg, fall} !== 3'b000) $display("FAIL fall_e6 got chg=%b fall=%b required chg=0 fall=00", chg, fall);
    else passes++;
    settle(2);
  endtask

  task automatic test_bounce();
    logic [1:0] pat [0:4];
    logic       saw_chg;
    pat[0] = 2'b10; pat[1] = 2'b11; pat[2] = 2'b10; pat[3] = 2'b11; pat[4] = 2'b10;
    saw_chg = 1'b0;
    for (int e = 0; e < 5; e++) begin
      d = pat[e];
      step();
      if (chg) saw_chg = 1'b1;
    end
    d = 2'b11;
    for (int e = 5; e < 10; e++) begin
      step();
      if (chg) saw_chg = 1'b1;
    end
    checks++;
    if ({q, saw_chg, busy} !== 4'b0001)
      $display("FAIL bounce_e9 got q=%b chg_seen=%b busy=%b required q=00 chg_seen=0 busy=1", q, saw_chg, busy);
    else passes++;
    step();
    checks++;
    if ({q, chg, rise, fall} !== 7'b11_1_11_00)
      $display("FAIL bounce_e10 got q=%b chg=%b rise=%b fall=%b required q=11 chg=1 rise=11 fall=00", q, chg, rise, fall);
    else passes++;
    step();
    checks++;
    if ({q, chg, rise} !== 5'b11_0_00) $display("FAIL bounce_e11 got q=%b chg=%b rise=%b required q=11 chg=0 rise=00", q, chg, rise);
    else passes++;
  endtask

  initial begin
    test_reset();
    test_glitch();
    test_clean_step();
    test_reset_mid_check();
    test_fall();
    test_bounce();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
